vdp_vram_host_write_queue: RTL and testbench
============================================

Name: vdp_vram_host_write_queue

Overview:
- Host-side VRAM write port that sits directly upstream of the VRAM bus arbiter.
- Holds the host VRAM address pointer and its auto-increment, and queues host data writes in a small FIFO.
- Presents the FIFO head as the arbiter's write address, data and write-enable mask.
- Retires the head entry when the arbiter grants its host-write slot (vram_written, once per 8 pixel cycles).

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
INCREMENT_RESET, 1, reset value of the address auto-increment.

Ports:
clk  input  1  system clock
reset_n  input  1  reset; asynchronous, active-low
host_address_we  input  1  load address pointer this cycle
host_address  input  15  word address; bit 0 selects bank (0 even, 1 odd), [14:1] is the bank address
host_increment_we  input  1  load increment this cycle
host_increment  input  8  value added to the pointer after each accepted data write
host_data_we  input  1  push one write of host_data at the current pointer
host_data  input  16  write data
host_overflow_clear  input  1  clear the sticky overflow flag
vram_written  input  1  arbiter host slot strobe; combinational from the arbiter
vram_write_address_16b  output  14  head entry address[14:1]
vram_write_data_16b  output  16  head entry data
vram_port_write_en_mask  output  2  head entry bank mask: 2'b01 even, 2'b10 odd, 2'b00 when empty
fifo_empty  output  1  no entries
fifo_full  output  1  DEPTH entries
fifo_level  output  $clog2(DEPTH)+1  entry count
overflow  output  1  sticky; a push was dropped

Behaviour:
- Reset (async assert, sync deassert by flop design) sets:
  - pointer = 0, increment = INCREMENT_RESET
  - FIFO empty, level 0, overflow 0
  - outputs: mask 2'b00, fifo_empty 1, fifo_full 0; address/data outputs 0
- FIFO storage: registered FIFO with read/write indices of width $clog2(DEPTH) that wrap modulo DEPTH.
- Head outputs:
  - Address and data are combinational from the head entry.
  - Mask is forced to 2'b00 whenever fifo_empty is 1, so the arbiter's registered we_even/we_odd stay low.
- Pop:
  - Occurs when vram_written=1 and the FIFO is not empty (evaluated from pre-edge state).
  - The arbiter samples the head in the same cycle, so the head advances on that edge.
  - vram_written while empty has no effect.
- Push:
  - Occurs when host_data_we=1, storing {pointer, host_data}.
  - Accepted if not full, or if full and a pop occurs in the same cycle (level stays DEPTH).
  - Otherwise the push is dropped: overflow sets to 1, and the pointer does NOT advance.
- No bypass: a push into an empty FIFO becomes visible on the outputs the cycle after the edge. The mask is 00 in the push cycle.
- Pointer update order within one cycle:
  - If host_address_we, the pointer takes host_address first.
  - Then, if host_data_we in the same cycle, the push uses the NEW address.
  - The post-push pointer is host_address + increment.
- Increment:
  - If host_increment_we and host_data_we coincide, the push's post-increment uses the OLD increment.
  - The new increment applies from the next write.
- Pointer arithmetic: 15-bit unsigned, pointer = (pointer + zero-extended increment) mod 2^15. 0x7FFF + 1 wraps to 0x0000.
- Increment of 0 is legal and gives repeated writes to the same word.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Overflow flag:
  - host_overflow_clear clears it.
  - A drop in the same cycle as host_overflow_clear wins, so the flag stays 1.
- Reset asserted mid-operation discards all queued entries immediately. No partial write reaches the arbiter, because the mask goes to 00 asynchronously.
- Throughput: at most one retire per 8 cycles (the arbiter slot rate). The host is responsible for pacing writes using fifo_full.

Test Plan:
1. Reset, then address 0x0004, increment 1, four data writes 0xA000..0xA003, no vram_written -> fifo_full=1, level 4; head address 0x0002, data 0xA000, mask 01.
2. From state 1, pulse vram_written every 8 cycles -> head sequence (0x0002, 01, A000), (0x0002, 10, A001), (0x0003, 01, A002), (0x0003, 10, A003); then fifo_empty=1, mask 00.
3. Full FIFO, fifth data write with no pop -> overflow=1, level stays 4, pointer unchanged. Repeat the push in a cycle with vram_written=1 -> push accepted, level 4, overflow remains 1 until host_overflow_clear.
4. Same-cycle host_address_we=0x7FFF, host_increment_we=0x02, host_data_we (old increment 1) -> entry address[14:1]=0x3FFF, mask 10; pointer becomes 0x0000. The next write goes to 0x0000 then 0x0002.
5. Empty FIFO, push and vram_written in the same cycle -> no pop, mask 00 that cycle; entry visible next cycle, level 1.
6. Three entries queued, reset_n low mid-stream -> outputs immediately mask 00, fifo_empty 1, level 0. After release, pointer 0, increment 1.

Source files
------------

// File: rtl/vdp_vram_host_write_queue.sv
// vdp_vram_host_write_queue
//   Host-side VRAM write port sitting in front of the VRAM bus arbiter.
//   It keeps the host address pointer and its auto-increment, and queues
//   host data writes in a small FIFO. The FIFO head is presented to the
//   arbiter as word address, data and bank write-enable mask. The head is
//   retired when the arbiter grants the host-write slot (vram_written).
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   host_address_we/_address     load the 15-bit word pointer
//   host_increment_we/_increment load the 8-bit pointer auto-increment
//   host_data_we/_data           push one write at the current pointer
//   host_overflow_clear          clear the sticky overflow flag
//   vram_written                 arbiter host slot strobe (retires head)
//   vram_write_address_16b       head address[14:1]
//   vram_write_data_16b          head data
//   vram_port_write_en_mask      01 even bank, 10 odd bank, 00 when empty
//   fifo_empty/_full/_level      FIFO occupancy
//   overflow                     sticky: a push was dropped
module vdp_vram_host_write_queue #(
   parameter int DEPTH           = 4,
   parameter int INCREMENT_RESET = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     host_address_we,
   input  logic [14:0]              host_address,
   input  logic                     host_increment_we,
   input  logic [7:0]               host_increment,
   input  logic                     host_data_we,
   input  logic [15:0]              host_data,
   input  logic                     host_overflow_clear,
   input  logic                     vram_written,
   output logic [13:0]              vram_write_address_16b,
   output logic [15:0]              vram_write_data_16b,
   output logic [1:0]               vram_port_write_en_mask,
   output logic                     fifo_empty,
   output logic                     fifo_full,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [14:0]   r_mem_addr [DEPTH];
   logic [15:0]   r_mem_data [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [AW:0]   r_level;
   logic [14:0]   r_ptr;
   logic [7:0]    r_inc;
   logic          r_ovf;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [14:0]   w_base;
   logic [14:0]   w_head_addr;
   logic [15:0]   w_head_data;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == (AW+1)'(DEPTH));

   // Pop decision uses pre-edge occupancy; the arbiter samples the head in
   // the same cycle it strobes vram_written.
   assign w_pop  = vram_written && !w_empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push = host_data_we && (!w_full || w_pop);
   assign w_drop = host_data_we && !w_push;

   // A same-cycle address load takes effect before the push.
   assign w_base = host_address_we ? host_address : r_ptr;

   assign w_head_addr = r_mem_addr[r_rd];
   assign w_head_data = r_mem_data[r_rd];

   // Level is async-reset, so on reset the mask drops to 00 at once and no
   // partial write can reach the arbiter. Address/data are also held at 0
   // while empty so stale storage never shows on the bus.
   assign vram_write_address_16b  = w_empty ? 14'd0 : w_head_addr[14:1];
   assign vram_write_data_16b     = w_empty ? 16'd0 : w_head_data;
   assign vram_port_write_en_mask = w_empty ? 2'b00 :
                                    (w_head_addr[0] ? 2'b10 : 2'b01);
   assign fifo_empty = w_empty;
   assign fifo_full  = w_full;
   assign fifo_level = r_level;
   assign overflow   = r_ovf;

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr] <= w_base;
         r_mem_data[r_wr] <= host_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_level <= '0;
         r_ptr   <= 15'd0;
         r_inc   <= 8'(INCREMENT_RESET);
         r_ovf   <= 1'b0;
      end else begin
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push) r_wr <= r_wr + 1'b1;

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase

         // Post-increment uses the increment held before this edge; a
         // dropped push leaves the pointer at the (possibly loaded) base.
         r_ptr <= w_push ? (w_base + {7'd0, r_inc}) : w_base;

         if (host_increment_we) r_inc <= host_increment;

         // A drop beats a simultaneous clear.
         if (w_drop)                   r_ovf <= 1'b1;
         else if (host_overflow_clear) r_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vdp_vram_host_write_queue.sv
module tb_vdp_vram_host_write_queue;

   localparam int DEPTH = 4;
   localparam int INC_RST = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        host_address_we = 1'b0;
   logic [14:0] host_address = '0;
   logic        host_increment_we = 1'b0;
   logic [7:0]  host_increment = '0;
   logic        host_data_we = 1'b0;
   logic [15:0] host_data = '0;
   logic        host_overflow_clear = 1'b0;
   logic        vram_written = 1'b0;
   logic [13:0] vram_write_address_16b;
   logic [15:0] vram_write_data_16b;
   logic [1:0]  vram_port_write_en_mask;
   logic        fifo_empty;
   logic        fifo_full;
   logic [2:0]  fifo_level;
   logic        overflow;

   vdp_vram_host_write_queue #(.DEPTH(DEPTH), .INCREMENT_RESET(INC_RST)) dut (
      .clk(clk), .reset_n(reset_n),
      .host_address_we(host_address_we), .host_address(host_address),
      .host_increment_we(host_increment_we), .host_increment(host_increment),
      .host_data_we(host_data_we), .host_data(host_data),
      .host_overflow_clear(host_overflow_clear), .vram_written(vram_written),
      .vram_write_address_16b(vram_write_address_16b),
      .vram_write_data_16b(vram_write_data_16b),
      .vram_port_write_en_mask(vram_port_write_en_mask),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_level(fifo_level), .overflow(overflow));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct { logic [14:0] a; logic [15:0] d; } ent_t;
   ent_t sbq[$];          // accepted, not yet retired, in order
   int   m_level = 0;
   int   m_ptr = 0;
   int   m_inc = INC_RST;
   bit   m_ovf = 0;

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            sbq.delete();
            m_level = 0; m_ptr = 0; m_inc = INC_RST; m_ovf = 0;
         end else begin
            bit pop, acc;
            int base;
            ent_t e;
            pop  = vram_written && (m_level > 0);
            base = host_address_we ? int'(host_address) : m_ptr;
            acc  = 0;
            if (host_data_we) begin
               if (m_level < DEPTH || pop) begin
                  acc = 1;
                  e.a = 15'(base); e.d = host_data;
                  sbq.push_back(e);
                  m_ptr = (base + m_inc) % 32768;
               end else begin
                  m_ovf = 1;
                  m_ptr = base;
               end
            end else m_ptr = base;
            if (!(host_data_we && !acc) && host_overflow_clear) m_ovf = 0;
            if (host_increment_we) m_inc = int'(host_increment);
            m_level = m_level + int'(acc) - int'(pop);
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("level", 32'(fifo_level), 32'(m_level));
         chk("empty", 32'(fifo_empty), 32'(m_level == 0));
         chk("full", 32'(fifo_full), 32'(m_level == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (m_level == 0) chk("mask_empty", 32'(vram_port_write_en_mask), 32'd0);
         if (vram_written && !fifo_empty) begin
            if (sbq.size() == 0) begin
               errors++; checks++;
               $display("FAIL retire: DUT retired an entry, scoreboard empty at %0t", $time);
            end else begin
               ent_t e;
               e = sbq.pop_front();
               chk("ret_addr", 32'(vram_write_address_16b), 32'(e.a[14:1]));
               chk("ret_mask", 32'(vram_port_write_en_mask), e.a[0] ? 32'd2 : 32'd1);
               chk("ret_data", 32'(vram_write_data_16b), 32'(e.d));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic aw, input logic [14:0] a, input logic iw,
                      input logic [7:0] i, input logic dw, input logic [15:0] d,
                      input logic oc, input logic vw);
      host_address_we = aw; host_address = a;
      host_increment_we = iw; host_increment = i;
      host_data_we = dw; host_data = d;
      host_overflow_clear = oc; vram_written = vw;
      @(posedge clk); #1;
      host_address_we = 0; host_increment_we = 0; host_data_we = 0;
      host_overflow_clear = 0; vram_written = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [15:0] d);
      cyc(0, 0, 0, 0, 1, d, 0, 0);
   endtask

   task automatic pulse();   // one arbiter slot: strobe then 7 quiet cycles
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      idle(7);
   endtask

   task automatic head(input string n, input logic [13:0] a, input logic [1:0] m,
                       input logic [15:0] d);
      chk({n, "_addr"}, 32'(vram_write_address_16b), 32'(a));
      chk({n, "_mask"}, 32'(vram_port_write_en_mask), 32'(m));
      chk({n, "_data"}, 32'(vram_write_data_16b), 32'(d));
   endtask

   task automatic drain();
      for (int k = 0; k < 64 && m_level > 0; k++) pulse();
      chk("drained", 32'(fifo_level), 32'd0);
   endtask

   initial begin
      logic [13:0] ea [4];
      logic [1:0]  em [4];
      ea[0] = 14'h2; ea[1] = 14'h2; ea[2] = 14'h3; ea[3] = 14'h3;
      em[0] = 2'b01; em[1] = 2'b10; em[2] = 2'b01; em[3] = 2'b10;

      #12;
      chk("rst_mask", 32'(vram_port_write_en_mask), 0);
      chk("rst_empty", 32'(fifo_empty), 1);
      chk("rst_full", 32'(fifo_full), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_addr", 32'(vram_write_address_16b), 0);
      chk("rst_data", 32'(vram_write_data_16b), 0);
      @(negedge clk); reset_n = 1;
      @(posedge clk); #1;

      // 1: fill four entries from word 4
      cyc(1, 15'h0004, 1, 8'd1, 1, 16'hA000, 0, 0);
      for (int k = 1; k < 4; k++) push(16'hA000 + 16'(k));
      chk("t1_full", 32'(fifo_full), 1);
      chk("t1_level", 32'(fifo_level), 4);
      head("t1", 14'h2, 2'b01, 16'hA000);

      // 2: retire one per arbiter slot
      for (int k = 0; k < 4; k++) begin
         head("t2", ea[k], em[k], 16'hA000 + 16'(k));
         pulse();
      end
      chk("t2_empty", 32'(fifo_empty), 1);
      chk("t2_mask", 32'(vram_port_write_en_mask), 0);

      // 3: overflow on full, then accepted push with a same-cycle pop
      cyc(1, 15'h0010, 0, 0, 1, 16'hB000, 0, 0);
      for (int k = 1; k < 4; k++) push(16'hB000 + 16'(k));
      push(16'hB004);
      chk("t3_ovf", 32'(overflow), 1);
      chk("t3_level", 32'(fifo_level), 4);
      cyc(0, 0, 0, 0, 1, 16'hB005, 0, 1);
      chk("t3_level2", 32'(fifo_level), 4);
      chk("t3_ovf2", 32'(overflow), 1);
      idle(2);
      chk("t3_ovf3", 32'(overflow), 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("t3_clr", 32'(overflow), 0);
      idle(5);
      for (int k = 0; k < 3; k++) pulse();
      head("t3_last", 14'h0A, 2'b01, 16'hB005);  // dropped push left pointer at 0x14
      drain();

      // 4: address load + increment load + push in one cycle
      cyc(1, 15'h7FFF, 1, 8'h02, 1, 16'hC000, 0, 0);
      head("t4a", 14'h3FFF, 2'b10, 16'hC000);
      push(16'hC001);
      push(16'hC002);
      idle(5);
      pulse();
      head("t4b", 14'h0, 2'b01, 16'hC001);
      pulse();
      head("t4c", 14'h1, 2'b01, 16'hC002);
      drain();

      // 5: push into empty with a same-cycle strobe: no bypass, no pop
      host_data_we = 1; host_data = 16'hD000; vram_written = 1;
      #2;
      chk("t5_mask_now", 32'(vram_port_write_en_mask), 0);
      @(posedge clk); #1;
      host_data_we = 0; vram_written = 0;
      chk("t5_level", 32'(fifo_level), 1);
      head("t5", 14'h2, 2'b01, 16'hD000);  // pointer was 0x0004 after t4
      idle(6);
      drain();

      // 6: async reset with three entries queued
      push(16'hE000); push(16'hE001); push(16'hE002);
      #3 reset_n = 0;
      #1;
      chk("t6_mask", 32'(vram_port_write_en_mask), 0);
      chk("t6_empty", 32'(fifo_empty), 1);
      chk("t6_level", 32'(fifo_level), 0);
      @(negedge clk); reset_n = 1;
      @(posedge clk); #1;
      push(16'hE100); push(16'hE101);
      head("t6_after", 14'h0, 2'b01, 16'hE100);
      idle(4);
      pulse();
      head("t6_after2", 14'h0, 2'b10, 16'hE101);
      drain();

      // random traffic, arbiter slot every 8 cycles
      for (int c = 0; c < 3000; c++) begin
         logic aw, iw, dw, oc;
         aw = ($urandom_range(0, 19) == 0);
         iw = ($urandom_range(0, 19) == 0);
         dw = ($urandom_range(0, 9) < 4);
         oc = ($urandom_range(0, 29) == 0);
         cyc(aw, 15'($urandom), iw, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
             dw, 16'($urandom), oc, (c % 8) == 7);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
